// File: rtl/exu_lsu_pkg.sv
// ============================================================================
// Module : exu_lsu_pkg
// Shared types for the load/store unit: FSM states, latched command record,
// write-enable lane patterns.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package exu_lsu_pkg;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'b00,
    LSU_CMD  = 2'b01,
    LSU_RSP  = 2'b10,
    LSU_DONE = 2'b11
  } lsu_state_e;

  typedef struct packed {
    logic [31:0] adr;
    logic        read;
    logic [31:0] wdat;
    logic [3:0]  wmask;
  } lsu_cmd_t;

  localparam logic [3:0] LSU_WEN_WORD = 4'b1111;
  localparam logic [3:0] LSU_WEN_HLO  = 4'b0011;
  localparam logic [3:0] LSU_WEN_HHI  = 4'b1100;

  function automatic logic [31:0] lsu_word_adr(input logic [31:0] adr);
    return {adr[31:2], 2'b00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/exu_lsu_wdat_align.sv
// ============================================================================
// Module : exu_lsu_wdat_align
// Combinational store-lane replication and read-priority byte mask.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module exu_lsu_wdat_align
  import exu_lsu_pkg::*;
(
  input  logic [3:0]  wen_i,
  input  logic        ren_i,
  input  logic [31:0] wdat_i,
  output logic [31:0] wdat_o,
  output logic [3:0]  wmask_o,
  output logic        access_o
);

  always_comb begin
    wdat_o = wdat_i;
    case (wen_i)
      LSU_WEN_WORD:                        wdat_o = wdat_i;
      LSU_WEN_HLO, LSU_WEN_HHI:            wdat_o = {2{wdat_i[15:0]}};
      4'b0001, 4'b0010, 4'b0100, 4'b1000:  wdat_o = {4{wdat_i[7:0]}};
      default:                             wdat_o = wdat_i;
    endcase
  end

  // A load that also carries write-enables is issued as a pure read.
  assign wmask_o  = ren_i ? 4'b0000 : wen_i;
  assign access_o = ren_i | (|wen_i);

endmodule

`default_nettype wire

// File: rtl/exu_lsu.sv
// ============================================================================
// Module : exu_lsu
// Single-outstanding load/store bus FSM (IDLE/CMD/RSP/DONE).
// Optional response timeout enabled by macro CIRNO_LSU_TIMEOUT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module exu_lsu
  import exu_lsu_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hs_ag4ls_val,
  output logic        hs_ls4ag_rdy,
  input  logic [31:0] i_ls_adr,
  input  logic [31:0] i_ls_wdat,
  input  logic [3:0]  i_ls_wen,
  input  logic        i_ls_ren,
  output logic [31:0] o_ls_rdat,
  output logic        o_ls_err,
  output logic        o_bus_cmd_val,
  input  logic        i_bus_cmd_rdy,
  output logic [31:0] o_bus_cmd_adr,
  output logic        o_bus_cmd_read,
  output logic [31:0] o_bus_cmd_wdat,
  output logic [3:0]  o_bus_cmd_wmask,
  input  logic        i_bus_rsp_val,
  output logic        o_bus_rsp_rdy,
  input  logic [31:0] i_bus_rsp_rdat,
  input  logic        i_bus_rsp_err
);

  logic [31:0] w_wdat;
  logic [3:0]  w_wmask;
  logic        w_access;
  logic        w_req;
  logic        w_timeout;
  lsu_cmd_t    w_cmd_in;

  lsu_state_e  state_q, state_d;
  lsu_cmd_t    cmd_q,   cmd_d;
  logic [31:0] rdat_q,  rdat_d;
  logic        err_q,   err_d;

  exu_lsu_wdat_align u_align (
    .wen_i    (i_ls_wen),
    .ren_i    (i_ls_ren),
    .wdat_i   (i_ls_wdat),
    .wdat_o   (w_wdat),
    .wmask_o  (w_wmask),
    .access_o (w_access)
  );

  assign w_req    = hs_ag4ls_val & w_access;
  assign w_cmd_in = '{adr:   lsu_word_adr(i_ls_adr),
                      read:  i_ls_ren,
                      wdat:  w_wdat,
                      wmask: w_wmask};

`ifdef CIRNO_LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Held at zero outside RSP, so it starts from zero on every RSP entry.
  assign cnt_d     = (state_q == LSU_RSP) ? cnt_q + 1'b1 : '0;
  assign w_timeout = (state_q == LSU_RSP) && (cnt_q == CNT_W'(TIMEOUT_CYC));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
  assign w_timeout          = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    rdat_d  = rdat_q;
    err_d   = err_q;
    case (state_q)
      LSU_IDLE: begin
        if (w_req) begin
          cmd_d   = w_cmd_in;
          state_d = i_bus_cmd_rdy ? LSU_RSP : LSU_CMD;
        end
      end
      LSU_CMD: begin
        if (i_bus_cmd_rdy) state_d = LSU_RSP;
      end
      LSU_RSP: begin
        // A response in the timeout cycle still wins.
        if (i_bus_rsp_val) begin
          rdat_d  = cmd_q.read ? i_bus_rsp_rdat : 32'h0;
          err_d   = i_bus_rsp_err;
          state_d = LSU_DONE;
        end else if (w_timeout) begin
          rdat_d  = 32'h0;
          err_d   = 1'b1;
          state_d = LSU_DONE;
        end
      end
      LSU_DONE: begin
        rdat_d  = 32'h0;
        err_d   = 1'b0;
        cmd_d   = '0;
        state_d = LSU_IDLE;
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LSU_IDLE;
      cmd_q   <= '0;
      rdat_q  <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      rdat_q  <= rdat_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    hs_ls4ag_rdy    = 1'b0;
    o_ls_rdat       = 32'h0;
    o_ls_err        = 1'b0;
    o_bus_cmd_val   = 1'b0;
    o_bus_cmd_adr   = 32'h0;
    o_bus_cmd_read  = 1'b0;
    o_bus_cmd_wdat  = 32'h0;
    o_bus_cmd_wmask = 4'h0;
    o_bus_rsp_rdy   = 1'b1;
    case (state_q)
      LSU_IDLE: begin
        hs_ls4ag_rdy  = ~w_req;
        o_bus_cmd_val = w_req;
        if (w_req) begin
          o_bus_cmd_adr   = w_cmd_in.adr;
          o_bus_cmd_read  = w_cmd_in.read;
          o_bus_cmd_wdat  = w_cmd_in.wdat;
          o_bus_cmd_wmask = w_cmd_in.wmask;
        end
      end
      LSU_CMD: begin
        o_bus_cmd_val   = 1'b1;
        o_bus_cmd_adr   = cmd_q.adr;
        o_bus_cmd_read  = cmd_q.read;
        o_bus_cmd_wdat  = cmd_q.wdat;
        o_bus_cmd_wmask = cmd_q.wmask;
      end
      LSU_RSP: begin
      end
      LSU_DONE: begin
        hs_ls4ag_rdy  = 1'b1;
        o_ls_rdat     = rdat_q;
        o_ls_err      = err_q;
        o_bus_rsp_rdy = 1'b0;
      end
      default: begin
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_exu_lsu.sv
// ============================================================================
// Module : tb_exu_lsu
// Self-checking bench for exu_lsu: directed vector table, reset/timeout
// sequences and randomized transactions against a transaction-level model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_exu_lsu;

  localparam int TO = 4;
`ifdef CIRNO_LSU_TIMEOUT_EN
  localparam int MAX_RSP = TO + 1;
`else
  localparam int MAX_RSP = 6;
`endif

  logic        clk, rst;
  logic        hs_ag4ls_val, hs_ls4ag_rdy;
  logic [31:0] i_ls_adr, i_ls_wdat;
  logic [3:0]  i_ls_wen;
  logic        i_ls_ren;
  logic [31:0] o_ls_rdat;
  logic        o_ls_err;
  logic        o_bus_cmd_val, i_bus_cmd_rdy;
  logic [31:0] o_bus_cmd_adr;
  logic        o_bus_cmd_read;
  logic [31:0] o_bus_cmd_wdat;
  logic [3:0]  o_bus_cmd_wmask;
  logic        i_bus_rsp_val, o_bus_rsp_rdy;
  logic [31:0] i_bus_rsp_rdat;
  logic        i_bus_rsp_err;

  exu_lsu #(.TIMEOUT_CYC(TO)) dut (
    .clk             (clk),
    .rst             (rst),
    .hs_ag4ls_val    (hs_ag4ls_val),
    .hs_ls4ag_rdy    (hs_ls4ag_rdy),
    .i_ls_adr        (i_ls_adr),
    .i_ls_wdat       (i_ls_wdat),
    .i_ls_wen        (i_ls_wen),
    .i_ls_ren        (i_ls_ren),
    .o_ls_rdat       (o_ls_rdat),
    .o_ls_err        (o_ls_err),
    .o_bus_cmd_val   (o_bus_cmd_val),
    .i_bus_cmd_rdy   (i_bus_cmd_rdy),
    .o_bus_cmd_adr   (o_bus_cmd_adr),
    .o_bus_cmd_read  (o_bus_cmd_read),
    .o_bus_cmd_wdat  (o_bus_cmd_wdat),
    .o_bus_cmd_wmask (o_bus_cmd_wmask),
    .i_bus_rsp_val   (i_bus_rsp_val),
    .o_bus_rsp_rdy   (o_bus_rsp_rdy),
    .i_bus_rsp_rdat  (i_bus_rsp_rdat),
    .i_bus_rsp_err   (i_bus_rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        ren;
    logic [3:0]  wen;
    logic [31:0] adr;
    logic [31:0] wdat;
    int          dly;
    int          nrsp;
    logic [31:0] rsp_d;
    logic        rsp_e;
    logic [31:0] e_adr;
    logic [31:0] e_wdat;
    logic [3:0]  e_mask;
    logic [31:0] e_rdat;
    logic        e_err;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Each byte lane takes the store byte whose index is the lane modulo access size.
  function automatic logic [31:0] ref_wdat(input logic [3:0] wen, input logic [31:0] d);
    int sz;
    logic [31:0] r;
    sz = $countones(wen);
    r  = d;
    if (sz != 0)
      for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % sz) +: 8];
    return r;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle(input bit stray);
    hs_ag4ls_val   = 1'b0;
    i_ls_ren       = 1'($urandom);
    i_ls_wen       = 4'($urandom);
    i_bus_cmd_rdy  = 1'($urandom);
    i_bus_rsp_val  = stray ? 1'($urandom) : 1'b0;
    i_bus_rsp_rdat = $urandom;
    i_bus_rsp_err  = 1'($urandom);
    @(negedge clk);
    chk("idle_rdy",     32'(hs_ls4ag_rdy),  32'd1);
    chk("idle_cmd_val", 32'(o_bus_cmd_val), 32'd0);
    chk("idle_rdat",    o_ls_rdat,          32'd0);
    chk("idle_err",     32'(o_ls_err),      32'd0);
    chk("idle_rsp_rdy", 32'(o_bus_rsp_rdy), 32'd1);
    next_cycle();
  endtask

  // One request: command accepted at cycle dly, response at dly+nrsp, ready one later.
  task automatic run_txn(input vec_t v, input bit strays);
    int  total;
    bit  acc;
    acc            = v.ren | (|v.wen);
    hs_ag4ls_val   = 1'b1;
    i_ls_ren       = v.ren;
    i_ls_wen       = v.wen;
    i_ls_adr       = v.adr;
    i_ls_wdat      = v.wdat;
    if (!acc) begin
      i_bus_cmd_rdy = 1'($urandom);
      i_bus_rsp_val = 1'b0;
      @(negedge clk);
      chk("nomem_rdy",     32'(hs_ls4ag_rdy),  32'd1);
      chk("nomem_cmd_val", 32'(o_bus_cmd_val), 32'd0);
      chk("nomem_rdat",    o_ls_rdat,          32'd0);
      chk("nomem_err",     32'(o_ls_err),      32'd0);
      next_cycle();
      hs_ag4ls_val = 1'b0;
      return;
    end
    total = v.dly + v.nrsp + 1;
    for (int c = 0; c <= total; c++) begin
      i_bus_cmd_rdy = (c == v.dly) ? 1'b1 : ((c > v.dly) ? 1'($urandom) : 1'b0);
      if (c == v.dly + v.nrsp) begin
        i_bus_rsp_val  = 1'b1;
        i_bus_rsp_rdat = v.rsp_d;
        i_bus_rsp_err  = v.rsp_e;
      end else begin
        i_bus_rsp_val  = (strays && c <= v.dly) ? 1'($urandom) : 1'b0;
        i_bus_rsp_rdat = $urandom;
        i_bus_rsp_err  = 1'($urandom);
      end
      @(negedge clk);
      if (c <= v.dly) begin
        chk("cmd_val",   32'(o_bus_cmd_val),   32'd1);
        chk("cmd_adr",   o_bus_cmd_adr,        v.e_adr);
        chk("cmd_read",  32'(o_bus_cmd_read),  32'(v.ren));
        chk("cmd_wmask", 32'(o_bus_cmd_wmask), 32'(v.e_mask));
        if (!v.ren) chk("cmd_wdat", o_bus_cmd_wdat, v.e_wdat);
        chk("cmd_rdy_lo", 32'(hs_ls4ag_rdy),   32'd0);
      end else if (c < total) begin
        chk("rsp_cmd_val", 32'(o_bus_cmd_val), 32'd0);
        chk("rsp_rdy_lo",  32'(hs_ls4ag_rdy),  32'd0);
        chk("rsp_rsp_rdy", 32'(o_bus_rsp_rdy), 32'd1);
      end else begin
        chk("done_rdy",     32'(hs_ls4ag_rdy),  32'd1);
        chk("done_rdat",    o_ls_rdat,          v.e_rdat);
        chk("done_err",     32'(o_ls_err),      32'(v.e_err));
        chk("done_cmd_val", 32'(o_bus_cmd_val), 32'd0);
      end
      next_cycle();
    end
    hs_ag4ls_val  = 1'b0;
    i_bus_rsp_val = 1'b0;
    i_bus_cmd_rdy = 1'b0;
  endtask

  function automatic vec_t mk_vec(input logic ren, input logic [3:0] wen,
                                  input logic [31:0] adr, input logic [31:0] wdat,
                                  input int dly, input int nrsp,
                                  input logic [31:0] rsp_d, input logic rsp_e);
    vec_t v;
    v.ren    = ren;   v.wen  = wen;  v.adr   = adr;   v.wdat  = wdat;
    v.dly    = dly;   v.nrsp = nrsp; v.rsp_d = rsp_d; v.rsp_e = rsp_e;
    v.e_adr  = adr & 32'hFFFF_FFFC;
    v.e_wdat = ref_wdat(wen, wdat);
    v.e_mask = ren ? 4'b0000 : wen;
    v.e_rdat = ren ? rsp_d : 32'h0;
    v.e_err  = rsp_e;
    return v;
  endfunction

  vec_t tbl[9];
  logic [3:0] wen_set[8] = '{4'b0000, 4'b1111, 4'b0011, 4'b1100,
                             4'b0001, 4'b0010, 4'b0100, 4'b1000};

  initial begin
    // ren, wen, adr, wdat, dly, nrsp, rsp_d, rsp_e, e_adr, e_wdat, e_mask, e_rdat, e_err
    tbl[0] = '{1'b1, 4'b0000, 32'h0000_1004, 32'h0, 0, 1, 32'hDEAD_BEEF, 1'b0,
               32'h0000_1004, 32'h0, 4'b0000, 32'hDEAD_BEEF, 1'b0};
    tbl[1] = '{1'b0, 4'b1000, 32'h0000_2003, 32'h1234_56AB, 0, 2, 32'h5555_5555, 1'b0,
               32'h0000_2000, 32'hABAB_ABAB, 4'b1000, 32'h0, 1'b0};
    tbl[2] = '{1'b0, 4'b1100, 32'h0000_3002, 32'h0000_BEEF, 3, 2, 32'h0, 1'b0,
               32'h0000_3000, 32'hBEEF_BEEF, 4'b1100, 32'h0, 1'b0};
    tbl[3] = '{1'b1, 4'b0000, 32'h0000_4008, 32'h0, 1, 3, 32'hCAFE_F00D, 1'b1,
               32'h0000_4008, 32'h0, 4'b0000, 32'hCAFE_F00D, 1'b1};
    tbl[4] = '{1'b1, 4'b1111, 32'h0000_500C, 32'h1122_3344, 0, 1, 32'h0BAD_F00D, 1'b0,
               32'h0000_500C, 32'h0, 4'b0000, 32'h0BAD_F00D, 1'b0};
    tbl[5] = '{1'b0, 4'b1111, 32'h0000_6000, 32'h89AB_CDEF, 2, 1, 32'h7777_7777, 1'b1,
               32'h0000_6000, 32'h89AB_CDEF, 4'b1111, 32'h0, 1'b1};
    tbl[6] = '{1'b0, 4'b0011, 32'h0000_7000, 32'hA5A5_1234, 1, 1, 32'h0, 1'b0,
               32'h0000_7000, 32'h1234_1234, 4'b0011, 32'h0, 1'b0};
    tbl[7] = '{1'b0, 4'b0010, 32'h0000_7001, 32'h0000_00C3, 0, 4, 32'h0, 1'b0,
               32'h0000_7000, 32'hC3C3_C3C3, 4'b0010, 32'h0, 1'b0};
    tbl[8] = '{1'b0, 4'b0000, 32'h0000_8000, 32'h0, 0, 1, 32'h0, 1'b0,
               32'h0, 32'h0, 4'b0000, 32'h0, 1'b0};

    rst = 1'b1;
    hs_ag4ls_val = 1'b0; i_ls_adr = 32'h0; i_ls_wdat = 32'h0; i_ls_wen = 4'h0; i_ls_ren = 1'b0;
    i_bus_cmd_rdy = 1'b0; i_bus_rsp_val = 1'b0; i_bus_rsp_rdat = 32'h0; i_bus_rsp_err = 1'b0;
    @(negedge clk);
    chk("rst_rdy",     32'(hs_ls4ag_rdy),  32'd1);
    chk("rst_cmd_val", 32'(o_bus_cmd_val), 32'd0);
    chk("rst_rdat",    o_ls_rdat,          32'd0);
    chk("rst_err",     32'(o_ls_err),      32'd0);
    chk("rst_rsp_rdy", 32'(o_bus_rsp_rdy), 32'd1);
    next_cycle();
    rst = 1'b0;
    idle_cycle(1'b0);

    for (int i = 0; i < 9; i++) begin
      run_txn(tbl[i], 1'b0);
      idle_cycle(1'b0);
    end

    // Reset while waiting in RSP, then the orphaned response arrives.
    hs_ag4ls_val = 1'b1; i_ls_ren = 1'b1; i_ls_wen = 4'b0000; i_ls_adr = 32'h0000_9000;
    i_bus_cmd_rdy = 1'b1;
    next_cycle();
    hs_ag4ls_val = 1'b0; i_bus_cmd_rdy = 1'b0;
    #1 rst = 1'b1;
    @(negedge clk);
    chk("midrst_cmd_val", 32'(o_bus_cmd_val), 32'd0);
    chk("midrst_rdy",     32'(hs_ls4ag_rdy),  32'd1);
    chk("midrst_rdat",    o_ls_rdat,          32'd0);
    next_cycle();
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      hs_ag4ls_val = 1'b0;
      i_bus_rsp_val = (k == 0); i_bus_rsp_rdat = 32'hFFFF_FFFF; i_bus_rsp_err = 1'b1;
      @(negedge clk);
      chk("drain_rdy",     32'(hs_ls4ag_rdy),  32'd1);
      chk("drain_rdat",    o_ls_rdat,          32'd0);
      chk("drain_err",     32'(o_ls_err),      32'd0);
      chk("drain_cmd_val", 32'(o_bus_cmd_val), 32'd0);
      next_cycle();
    end
    i_bus_rsp_val = 1'b0;
    run_txn(tbl[0], 1'b0);

`ifdef CIRNO_LSU_TIMEOUT_EN
    // No response: RSP entered at cycle 1, forced completion at cycle 1+TO+1.
    hs_ag4ls_val = 1'b1; i_ls_ren = 1'b1; i_ls_wen = 4'b0000; i_ls_adr = 32'h0000_A000;
    i_bus_cmd_rdy = 1'b1; i_bus_rsp_val = 1'b0;
    for (int c = 0; c <= TO + 2; c++) begin
      @(negedge clk);
      if (c <= TO + 1) chk("to_rdy_lo", 32'(hs_ls4ag_rdy), 32'(c == 0 ? 0 : 0));
      else begin
        chk("to_rdy",  32'(hs_ls4ag_rdy), 32'd1);
        chk("to_err",  32'(o_ls_err),     32'd1);
        chk("to_rdat", o_ls_rdat,         32'd0);
      end
      next_cycle();
      i_bus_cmd_rdy = 1'b0;
    end
    hs_ag4ls_val = 1'b0;
    i_bus_rsp_val = 1'b1; i_bus_rsp_rdat = 32'h1234_5678; i_bus_rsp_err = 1'b0;
    @(negedge clk);
    chk("to_late_rdy",  32'(hs_ls4ag_rdy), 32'd1);
    chk("to_late_rdat", o_ls_rdat,         32'd0);
    next_cycle();
    i_bus_rsp_val = 1'b0;
    run_txn(mk_vec(1'b1, 4'b0000, 32'h0000_B000, 32'h0, 0, TO + 1, 32'h600D_CAFE, 1'b0), 1'b0);
`endif

    for (int n = 0; n < 200; n++) begin
      logic [3:0]  wen;
      logic [31:0] adr;
      wen = wen_set[$urandom_range(7, 0)];
      adr = $urandom;
      if (wen == 4'b1111) adr[1:0] = 2'b00;
      else if (wen == 4'b0011) adr[1:0] = 2'b00;
      else if (wen == 4'b1100) adr[1:0] = 2'b10;
      run_txn(mk_vec(1'($urandom), wen, adr, $urandom,
                     $urandom_range(3, 0), $urandom_range(MAX_RSP, 1),
                     $urandom, 1'($urandom)), 1'b1);
      for (int g = 0; g < int'($urandom_range(2, 0)); g++) idle_cycle(1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire
